systolic_row_feeder: RTL
========================

Name: systolic_row_feeder

Overview:
- Downstream consumer of the operand buffer's stream port. It drives the buffer's 2-bit state input to pull 64-bit double-words and unpacks each into two 32-bit lanes.
- It applies a one-cycle diagonal skew so each lane enters the systolic array edge correctly aligned.
- It provides credit-based flow control against an array stall, using a small internal FIFO.

Parameters:
- TILE_LEN, 8, number of 64-bit words fetched per tile (1..255).
- FIFO_DEPTH, 4, internal FIFO depth in 64-bit words (power of 2, ≥2).

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-low reset.
- start  input  1  single-cycle pulse; starts one tile. Sampled only in IDLE.
- stall  input  1  array back-pressure; while high, no pops and no lane valids.
- buf_data  input  64  buffer data_out. Bits [63:32] are element 2k and bits [31:0] are element 2k+1.
- buf_state  output  2  buffer state command: 2'b10 = stream request, 2'b00 = idle. Never 2'b01.
- lane0_data  output  32  row-0 operand.
- lane0_valid  output  1  lane0_data is valid this cycle.
- lane1_data  output  32  row-1 operand.
- lane1_valid  output  1  lane1_data is valid this cycle.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse when the tile is fully emitted.

Behaviour:
- Reset (rst=0 at an edge) clears all state:
  - FSM goes to IDLE; FIFO is empty; pend=0; fetch_cnt=0; skew register=0.
  - Outputs: buf_state=00, lane*_data=0, lane*_valid=0, busy=0, done=0.
  - Reset mid-tile abandons the tile. There is no done pulse, and the buffer sees 00 from the next cycle.
- FSM states: IDLE, FETCH, FLUSH, DONE.
  - IDLE -> FETCH on start=1; fetch_cnt is cleared.
  - FETCH -> FLUSH when fetch_cnt==TILE_LEN, pend==0, the FIFO is empty and the last pop has occurred.
  - FLUSH -> DONE after the pending lane1 element is emitted. FLUSH holds while stall=1.
  - DONE -> IDLE after one cycle; done=1 only in DONE.
- start while busy=1 is ignored.
- Request (combinational) in FETCH: buf_state=10 iff fetch_cnt<TILE_LEN and fifo_count+pend<FIFO_DEPTH. Otherwise buf_state=00.
  - Each request increments fetch_cnt and sets pend=1 for the next cycle.
- Capture: the buffer returns data one edge after a request.
  - At the edge where pend==1, buf_data is pushed into the FIFO.
  - This push happens regardless of stall; the credit rule guarantees no overflow.
- Pop: at an edge with FIFO non-empty and stall=0, pop one word.
  - lane0_data<=word[63:32] and lane0_valid<=1.
  - word[31:0] goes into the skew register.
- Skew output at each non-stall edge:
  - lane1_data<=skew register; lane1_valid<=1 iff the skew register was loaded by the previous pop.
  - Element 2k on lane0 at cycle t gives element 2k+1 on lane1 at cycle t+1.
- Stall=1 at an edge:
  - Both valids go to 0.
  - Data registers and the skew register hold their values.
  - The skew relationship is preserved across the stall.
- Simultaneous push and pop in one cycle: fifo_count is unchanged.
- FIFO pointers wrap modulo FIFO_DEPTH.
- Latency, with no stall, counting from the edge that samples start (E0):
  - buf_state=10 during E0–E1.
  - First push at E2.
  - lane0_valid after E3.
  - lane1_valid after E4.
- Throughput: one word per cycle sustained.

Optional Feature:
- ROW_FEEDER_SKEW_EN defined (default build):
  - Skew behaviour exactly as above.
  - The FLUSH state exists.
- ROW_FEEDER_SKEW_EN undefined:
  - lane1_data<=word[31:0] at the same pop edge as lane0, and lane1_valid equals lane0_valid.
  - FLUSH is skipped: FETCH -> DONE directly, so done comes one cycle earlier.
  - The skew register is not instantiated.

Test Plan:
- Reset: hold rst=0 for 2 cycles with start=1 -> all outputs 0, buf_state=00, busy=0 throughout.
- Nominal, TILE_LEN=4: the buffer model returns 0x00000001_00000002, 0x00000003_00000004, ….
  - buf_state=10 for exactly 4 consecutive cycles starting during E0–E1.
  - lane0 = 1,3,5,7 on consecutive cycles from E3.
  - lane1 = 2,4,6,8 one cycle behind.
  - done pulses exactly once, one cycle after lane1 shows 8; busy falls with it.
- Stall, FIFO_DEPTH=4, TILE_LEN=8: stall=1 for 12 cycles after start.
  - Exactly 4 requests are issued and no lane valids appear.
  - After release, all 16 elements emerge in order with no loss or duplication.
  - Stall 1 cycle mid-stream -> both valids drop for 1 cycle, and lane1 resumes with the held element.
- start pulsed every cycle during a tile -> exactly TILE_LEN requests and a single done.
- rst=0 for 1 cycle mid-tile, after 3 requests:
  - Next cycle buf_state=00, valids 0, busy 0.
  - A following start issues a fresh TILE_LEN requests and emits a full tile.
- Build without ROW_FEEDER_SKEW_EN, repeating the nominal test -> lane0/lane1 pairs (1,2),(3,4),(5,6),(7,8) on the same cycles, and done one cycle earlier than in the skewed build.

Source files
------------

// File: rtl/systolic_row_feeder.sv
// rtl/systolic_row_feeder.sv - operand-buffer stream consumer feeding two skewed systolic lanes
//
// Pulls TILE_LEN 64-bit double-words from the operand buffer, stages them in
// a small credit-protected FIFO and unpacks each word into two 32-bit lanes.
// Lane 1 trails lane 0 by one non-stalled cycle so both rows enter the array
// edge diagonally aligned.
//
// Build option: ROW_FEEDER_SKEW_EN
//   defined   - lane 1 is delayed through a skew register; FLUSH state drains it.
//   undefined - both halves of a word leave on the same cycle; FETCH goes
//               straight to DONE.
//
// Parameters:
//   TILE_LEN    words fetched per tile (1..255)
//   FIFO_DEPTH  internal FIFO depth in words (power of 2, >= 2)
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-low reset
//   start        one-cycle tile start, honoured only while idle
//   stall        array back-pressure: no pops, no lane valids
//   buf_data     buffer data_out; [63:32] = element 2k, [31:0] = element 2k+1
//   buf_state    buffer command: 2'b10 stream request, 2'b00 idle
//   lane0_data   row-0 operand
//   lane0_valid  lane0_data valid
//   lane1_data   row-1 operand
//   lane1_valid  lane1_data valid
//   busy         high whenever not idle
//   done         one-cycle pulse once the whole tile has been emitted

module systolic_row_feeder #(
    parameter int TILE_LEN   = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stall,
    input  logic [63:0] buf_data,
    output logic [1:0]  buf_state,
    output logic [31:0] lane0_data,
    output logic        lane0_valid,
    output logic [31:0] lane1_data,
    output logic        lane1_valid,
    output logic        busy,
    output logic        done
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    localparam logic [7:0]       TILE_LEN_C = 8'(TILE_LEN);
    localparam logic [CNT_W:0]   DEPTH_C    = (CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [7:0]        r_fetch_cnt;
    logic              r_pend;

    logic [63:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    logic [31:0]       r_lane0_data;
    logic              r_lane0_valid;
    logic [31:0]       r_lane1_data;
    logic              r_lane1_valid;

`ifdef ROW_FEEDER_SKEW_EN
    logic [31:0]       r_skew;
    logic              r_skew_vld;
`endif

    logic              w_req;
    logic              w_push;
    logic              w_pop;
    logic              w_fetch_left;
    logic              w_credit_ok;
    logic              w_drained;
    logic [63:0]       w_pop_word;

    // Words already requested but not yet popped are the FIFO occupancy plus
    // the one in flight from the buffer; a new request is only safe while
    // that total leaves a free slot, which makes an unconditional push legal.
    assign w_fetch_left = (r_fetch_cnt < TILE_LEN_C);
    assign w_credit_ok  = (({1'b0, r_count} + {{CNT_W{1'b0}}, r_pend}) < DEPTH_C);
    assign w_drained    = (r_fetch_cnt == TILE_LEN_C) && !r_pend && (r_count == '0);

    assign w_push     = r_pend;
    assign w_pop      = (r_count != '0) && !stall;
    assign w_pop_word = r_mem[r_rd_ptr];

    always_comb begin
        w_state_nxt = r_state;
        w_req       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                w_req = w_fetch_left && w_credit_ok;
                if (w_drained) begin
`ifdef ROW_FEEDER_SKEW_EN
                    w_state_nxt = S_FLUSH;
`else
                    w_state_nxt = S_DONE;
`endif
                end
            end
            S_FLUSH: begin
`ifdef ROW_FEEDER_SKEW_EN
                // Leave only once the trailing lane-1 element has gone out
                // and the array is accepting again.
                if (!stall && !r_skew_vld) begin
                    w_state_nxt = S_DONE;
                end
`else
                w_state_nxt = S_DONE;
`endif
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_fetch_cnt <= '0;
            r_pend      <= 1'b0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
        end else begin
            r_state <= w_state_nxt;

            if (r_state == S_IDLE && start) begin
                r_fetch_cnt <= '0;
            end else if (w_req) begin
                r_fetch_cnt <= r_fetch_cnt + 8'd1;
            end

            // Buffer answers one edge after a request.
            r_pend <= w_req;

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (rst && w_push) begin
            r_mem[r_wr_ptr] <= buf_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_lane0_data  <= '0;
            r_lane0_valid <= 1'b0;
            r_lane1_data  <= '0;
            r_lane1_valid <= 1'b0;
`ifdef ROW_FEEDER_SKEW_EN
            r_skew        <= '0;
            r_skew_vld    <= 1'b0;
`endif
        end else if (stall) begin
            // Data and skew state freeze so lane 1 resumes with the element
            // that belongs to the last lane-0 pop.
            r_lane0_valid <= 1'b0;
            r_lane1_valid <= 1'b0;
        end else begin
            r_lane0_valid <= w_pop;
            if (w_pop) begin
                r_lane0_data <= w_pop_word[63:32];
            end
`ifdef ROW_FEEDER_SKEW_EN
            r_lane1_data  <= r_skew;
            r_lane1_valid <= r_skew_vld;
            r_skew_vld    <= w_pop;
            if (w_pop) begin
                r_skew <= w_pop_word[31:0];
            end
`else
            r_lane1_valid <= w_pop;
            if (w_pop) begin
                r_lane1_data <= w_pop_word[31:0];
            end
`endif
        end
    end

    assign buf_state   = w_req ? 2'b10 : 2'b00;
    assign lane0_data  = r_lane0_data;
    assign lane0_valid = r_lane0_valid;
    assign lane1_data  = r_lane1_data;
    assign lane1_valid = r_lane1_valid;
    assign busy        = (r_state != S_IDLE);
    assign done        = (r_state == S_DONE);

endmodule
